placed_board_ctrl: RTL and testbench
====================================

// Module: placed_board_ctrl
// PURPOSE
//  Owns the single-port placed-card board RAM (SIZE x DEPTH, 1-cycle registered read, write-first-cycle).
//  Shares it between the game-logic port (read/write) and the display-scan port (read-only).
//  Runs a clear sequencer that wipes every cell to CLEAR_VALUE after reset or on request.
//  Sits between game FSM / display driver and the board RAM instance.
// PARAMETERS
//  SIZE        4   bits per board cell
//  DEPTH       16  number of cells; must be >= 2
//  CLEAR_VALUE 0   value written to every cell by the clear sequencer
// PORTS
//  clk          in   1       system clock; sole clock
//  rst          in   1       synchronous, active-high reset
//  clear_req    in   1       pulse: start full-board clear
//  clear_busy   out  1       high while clear sequencer owns the RAM
//  game_req     in   1       game-logic access request; held with addr/we/wdata until game_ack
//  game_we      in   1       1 = write, 0 = read
//  game_addr    in   AW      cell address (AW = $clog2(DEPTH))
//  game_wdata   in   SIZE    write data
//  game_ack     out  1       request accepted this cycle
//  game_rdata   out  SIZE    read data, valid with game_rvalid
//  game_rvalid  out  1       one-cycle pulse, cycle after a read ack
//  disp_req     in   1       display read request; held with disp_addr until disp_ack
//  disp_addr    in   AW      cell address
//  disp_ack     out  1       request accepted this cycle
//  disp_rdata   out  SIZE    read data, valid with disp_rvalid
//  disp_rvalid  out  1       one-cycle pulse, cycle after a disp ack
//  ram_addr     out  AW      to RAM address
//  ram_wdata    out  SIZE    to RAM write_data
//  ram_we       out  1       to RAM write_en
//  ram_rdata    in   SIZE    from RAM read_data (registered, 1-cycle latency)
// BEHAVIOUR
//  - States: CLEAR, SERVE. rst -> CLEAR, clear count = 0; during rst ram_we = 0, acks = 0, rvalids = 0.
//  - clear_busy = (state == CLEAR); therefore 1 during and after reset until clear completes.
//  - CLEAR: ram_we = 1, ram_addr = count, ram_wdata = CLEAR_VALUE; count++ per cycle; after addr DEPTH-1 -> SERVE.
//    Exactly DEPTH write cycles. No acks issued; requests stay pending. clear_req during CLEAR ignored.
//  - SERVE: per cycle grant at most one requester; ack is combinational from req and grant decision.
//    Granted port drives ram_addr/ram_we/ram_wdata same cycle; disp never writes.
//  - rvalid: registered; asserts cycle after a read ack to that port; rdata = ram_rdata (pass-through).
//    Write acks produce no rvalid. Back-to-back acks to the same port allowed every cycle.
//  - Read of a cell written the previous cycle returns the new value; same-cycle read/write impossible (one grant).
//  - clear_req in SERVE: no ack that cycle; next cycle -> CLEAR, count = 0. An rvalid owed from prior cycle still issues.
//  - Idle SERVE (no req): ram_we = 0, ram_addr = 0.
//  - Reset mid-CLEAR restarts the sweep at address 0.
// CONFIGURATION
//  PLACED_RR_ARB_EN defined: two-way round-robin; on contention grant the port not granted last
//    (last-grant pointer resets to disp, so first contention goes to game).
//  Not defined: fixed priority, game > disp; display may starve while game_req held.
// STRUCTURE
//  placed_pkg: state enum (CLEAR, SERVE), port-index constants GAME = 0, DISP = 1.
//  Sub-module placed_rr_arbiter: 2-way req/grant + last-grant pointer; fixed priority when macro off.
// TESTING (SIZE=4, DEPTH=16, CLEAR_VALUE=4'hF)
//  1 Release rst -> clear_busy high exactly 16 cycles, ram_we each cycle, addrs 0..15, wdata F; then clear_busy 0.
//  2 game write addr 5 data 3, then game read addr 5 -> game_ack both cycles; game_rvalid next cycle, game_rdata = 3.
//  3 game_req+disp_req both held, 6 cycles: macro off -> 6 game acks, 0 disp; macro on -> alternating G,D,G,D,G,D.
//  4 clear_req pulse with disp read pending -> no disp_ack; clear_busy 16 cycles; disp_ack first SERVE cycle, rdata F.
//  5 rst asserted at clear count 7 -> after release sweep restarts at addr 0, still 16 write cycles.
//  6 disp read addr 9 after clear -> disp_rvalid 1 cycle later, disp_rdata F, game_rvalid stays 0.

Source files
------------

// File: rtl/placed_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : placed_pkg
//  Purpose  : Shared types and constants for the placed-card board controller.
//             Controller state enum and requester port indices.
//  Revision : 1.0  initial release
// ============================================================================
package placed_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } state_t;

  // Bit positions of each requester inside the arbiter req/grant vectors
  localparam int GAME = 0;
  localparam int DISP = 1;

endpackage
`default_nettype wire

// File: rtl/placed_board_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : placed_board_ctrl_if
//  Purpose  : Bundles the game-logic port, display-scan port and board-RAM
//             port of the placed-card board controller.
//  Modports : slave  - the controller (receives requests, drives RAM)
//             master - surroundings (game FSM, display driver, RAM model)
//  Revision : 1.0  initial release
// ============================================================================
interface placed_board_ctrl_if #(
  parameter int SIZE  = 4,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  // game-logic port
  logic            game_req;
  logic            game_we;
  logic [AW-1:0]   game_addr;
  logic [SIZE-1:0] game_wdata;
  logic            game_ack;
  logic [SIZE-1:0] game_rdata;
  logic            game_rvalid;
  // display-scan port (read-only)
  logic            disp_req;
  logic [AW-1:0]   disp_addr;
  logic            disp_ack;
  logic [SIZE-1:0] disp_rdata;
  logic            disp_rvalid;
  // board RAM port
  logic [AW-1:0]   ram_addr;
  logic [SIZE-1:0] ram_wdata;
  logic            ram_we;
  logic [SIZE-1:0] ram_rdata;

  modport slave (
    input  game_req, game_we, game_addr, game_wdata,
    output game_ack, game_rdata, game_rvalid,
    input  disp_req, disp_addr,
    output disp_ack, disp_rdata, disp_rvalid,
    output ram_addr, ram_wdata, ram_we,
    input  ram_rdata
  );

  modport master (
    output game_req, game_we, game_addr, game_wdata,
    input  game_ack, game_rdata, game_rvalid,
    output disp_req, disp_addr,
    input  disp_ack, disp_rdata, disp_rvalid,
    input  ram_addr, ram_wdata, ram_we,
    output ram_rdata
  );

endinterface
`default_nettype wire

// File: rtl/placed_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : placed_rr_arbiter
//  Purpose  : Two-way grant between the game and display requesters.
//             PLACED_RR_ARB_EN defined : round-robin on contention, the port
//               not granted last wins; pointer resets to "display last" so
//               the first contention goes to game.
//             PLACED_RR_ARB_EN undefined: fixed priority, game over display.
//  Ports    : clk, rst  clock / sync active-high reset (round-robin only)
//             i_en      grants allowed this cycle
//             i_req     request vector, indexed by GAME / DISP
//             o_grant   one-hot (or zero) grant vector, combinational
//  Revision : 1.0  initial release
// ============================================================================
module placed_rr_arbiter import placed_pkg::*; (
`ifdef PLACED_RR_ARB_EN
  input  logic       clk,
  input  logic       rst,
`endif
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant
);

`ifdef PLACED_RR_ARB_EN
  // 1 = display was granted most recently
  logic r_last_disp;

  always_comb begin
    o_grant = 2'b00;
    if (i_en) begin
      if (i_req[GAME] && i_req[DISP]) begin
        o_grant[GAME] = r_last_disp;
        o_grant[DISP] = !r_last_disp;
      end else begin
        o_grant = i_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_disp <= 1'b1;
    end else if (o_grant[GAME]) begin
      r_last_disp <= 1'b0;
    end else if (o_grant[DISP]) begin
      r_last_disp <= 1'b1;
    end
  end
`else
  always_comb begin
    o_grant       = 2'b00;
    o_grant[GAME] = i_en && i_req[GAME];
    o_grant[DISP] = i_en && i_req[DISP] && !i_req[GAME];
  end
`endif

endmodule
`default_nettype wire

// File: rtl/placed_board_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : placed_board_ctrl
//  Purpose  : Owns the single-port placed-card board RAM. Shares it between
//             the game-logic port (read/write) and the display-scan port
//             (read-only), and sweeps every cell to CLEAR_VALUE after reset
//             or on i_clear_req.
//  Ports    : clk           system clock
//             rst           synchronous active-high reset
//             i_clear_req   pulse: start full-board clear
//             o_clear_busy  high while the clear sequencer owns the RAM
//             bus           placed_board_ctrl_if.slave (game/disp/RAM)
//  Config   : PLACED_RR_ARB_EN selects round-robin arbitration (else fixed
//             priority game > display).
//  Revision : 1.0  initial release
// ============================================================================
module placed_board_ctrl import placed_pkg::*; #(
  parameter int SIZE        = 4,
  parameter int DEPTH       = 16,
  parameter int CLEAR_VALUE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clear_req,
  output logic                o_clear_busy,
  placed_board_ctrl_if.slave  bus
);

  localparam int              AW          = $clog2(DEPTH);
  localparam logic [AW-1:0]   C_LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [SIZE-1:0] C_CLEAR_VAL = SIZE'(CLEAR_VALUE);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_count;
  logic            r_game_rvalid;
  logic            r_disp_rvalid;
  logic            w_arb_en;
  logic [1:0]      w_req;
  logic [1:0]      w_grant;
  logic [AW-1:0]   w_ram_addr;
  logic [SIZE-1:0] w_ram_wdata;
  logic            w_ram_we;

  // A clear request in SERVE suppresses grants that same cycle so the sweep
  // starts from a quiet RAM; reset also blocks every grant.
  assign w_arb_en = (r_state == SERVE) && !i_clear_req && !rst;

  always_comb begin
    w_req       = 2'b00;
    w_req[GAME] = bus.game_req;
    w_req[DISP] = bus.disp_req;
  end

  placed_rr_arbiter u_arb (
`ifdef PLACED_RR_ARB_EN
    .clk     (clk),
    .rst     (rst),
`endif
    .i_en    (w_arb_en),
    .i_req   (w_req),
    .o_grant (w_grant)
  );

  // -------------------------------------------------------------------------
  // State register, sweep counter and read-valid pulses
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= CLEAR;
      r_count       <= '0;
      r_game_rvalid <= 1'b0;
      r_disp_rvalid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == CLEAR && r_count != C_LAST_ADDR) begin
        r_count <= r_count + 1'b1;
      end else begin
        r_count <= '0;
      end
      r_game_rvalid <= w_grant[GAME] && !bus.game_we;
      r_disp_rvalid <= w_grant[DISP];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CLEAR:   if (r_count == C_LAST_ADDR) w_state_nxt = SERVE;
      SERVE:   if (i_clear_req)            w_state_nxt = CLEAR;
      default: w_state_nxt = CLEAR;
    endcase
  end

  // -------------------------------------------------------------------------
  // RAM port mux: sweep, granted requester, or idle (addr 0, no write)
  // -------------------------------------------------------------------------
  always_comb begin
    w_ram_addr  = '0;
    w_ram_wdata = '0;
    w_ram_we    = 1'b0;
    if (!rst) begin
      if (r_state == CLEAR) begin
        w_ram_addr  = r_count;
        w_ram_wdata = C_CLEAR_VAL;
        w_ram_we    = 1'b1;
      end else if (w_grant[GAME]) begin
        w_ram_addr  = bus.game_addr;
        w_ram_wdata = bus.game_wdata;
        w_ram_we    = bus.game_we;
      end else if (w_grant[DISP]) begin
        w_ram_addr  = bus.disp_addr;
      end
    end
  end

  assign bus.ram_addr    = w_ram_addr;
  assign bus.ram_wdata   = w_ram_wdata;
  assign bus.ram_we      = w_ram_we;

  assign bus.game_ack    = w_grant[GAME];
  assign bus.disp_ack    = w_grant[DISP];
  assign bus.game_rvalid = r_game_rvalid;
  assign bus.disp_rvalid = r_disp_rvalid;
  // RAM read data is registered already; both ports see it directly
  assign bus.game_rdata  = bus.ram_rdata;
  assign bus.disp_rdata  = bus.ram_rdata;

  assign o_clear_busy    = (r_state == CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_placed_board_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_placed_board_ctrl
//  Purpose  : Directed self-checking bench for placed_board_ctrl with a
//             board-RAM model and read-data scoreboard queues.
//  Revision : 1.0  initial release
// ============================================================================
module tb_placed_board_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic clear_req;
  logic clear_busy;

  placed_board_ctrl_if #(.SIZE(4), .DEPTH(16)) bus ();

  placed_board_ctrl #(.SIZE(4), .DEPTH(16), .CLEAR_VALUE(15)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_clear_req  (clear_req),
    .o_clear_busy (clear_busy),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // Board RAM: 1-cycle registered read, written data visible on the read port
  logic [3:0] mem [16];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= bus.ram_we ? bus.ram_wdata : mem[bus.ram_addr];
  end

  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] shadow [16];
  logic [3:0] gq [$];
  logic [3:0] dq [$];
  bit         pend_g, pend_d;
  bit         last_disp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rv();
    chk("game_rvalid", {31'd0, bus.game_rvalid}, {31'd0, pend_g});
    if (pend_g && gq.size() > 0) chk("game_rdata", {28'd0, bus.game_rdata}, {28'd0, gq.pop_front()});
    chk("disp_rvalid", {31'd0, bus.disp_rvalid}, {31'd0, pend_d});
    if (pend_d && dq.size() > 0) chk("disp_rdata", {28'd0, bus.disp_rdata}, {28'd0, dq.pop_front()});
  endtask

  function automatic logic [1:0] model_grant();
    logic [1:0] g;
    g = 2'b00;
    if (clear_req) return g;
    if (bus.game_req && bus.disp_req) begin
`ifdef PLACED_RR_ARB_EN
      if (last_disp) g[0] = 1'b1; else g[1] = 1'b1;
`else
      g[0] = 1'b1;
`endif
    end else begin
      g = {bus.disp_req, bus.game_req};
    end
    return g;
  endfunction

  // Called at a negedge with inputs driven; checks, updates model, advances.
  task automatic serve_cyc(input bit eg, input bit ed);
    #1;
    chk("clear_busy", {31'd0, clear_busy}, 32'd0);
    chk("game_ack", {31'd0, bus.game_ack}, {31'd0, eg});
    chk("disp_ack", {31'd0, bus.disp_ack}, {31'd0, ed});
    if (eg) begin
      chk("ram_addr_g", {28'd0, bus.ram_addr}, {28'd0, bus.game_addr});
      chk("ram_we_g", {31'd0, bus.ram_we}, {31'd0, bus.game_we});
      if (bus.game_we) chk("ram_wdata", {28'd0, bus.ram_wdata}, {28'd0, bus.game_wdata});
    end else if (ed) begin
      chk("ram_addr_d", {28'd0, bus.ram_addr}, {28'd0, bus.disp_addr});
      chk("ram_we_d", {31'd0, bus.ram_we}, 32'd0);
    end else begin
      chk("ram_we_idle", {31'd0, bus.ram_we}, 32'd0);
      chk("ram_addr_idle", {28'd0, bus.ram_addr}, 32'd0);
    end
    chk_rv();
    pend_g = eg && !bus.game_we;
    if (pend_g) gq.push_back(shadow[bus.game_addr]);
    if (eg && bus.game_we) shadow[bus.game_addr] = bus.game_wdata;
    pend_d = ed;
    if (pend_d) dq.push_back(shadow[bus.disp_addr]);
    if (eg) last_disp = 1'b0;
    else if (ed) last_disp = 1'b1;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      logic [1:0] g;
      g = model_grant();
      serve_cyc(g[0], g[1]);
    end
  endtask

  // Clear sweep for n cells starting at address 0
  task automatic sweep(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      chk("clr_busy", {31'd0, clear_busy}, 32'd1);
      chk("clr_we", {31'd0, bus.ram_we}, 32'd1);
      chk("clr_addr", {28'd0, bus.ram_addr}, i);
      chk("clr_wdata", {28'd0, bus.ram_wdata}, 32'hF);
      chk("clr_gack", {31'd0, bus.game_ack}, 32'd0);
      chk("clr_dack", {31'd0, bus.disp_ack}, 32'd0);
      chk_rv();
      pend_g = 1'b0;
      pend_d = 1'b0;
      shadow[i] = 4'hF;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clear_req = 1'b0;
    bus.game_req = 1'b1; bus.game_we = 1'b0; bus.game_addr = '0; bus.game_wdata = '0;
    bus.disp_req = 1'b1; bus.disp_addr = '0;
    for (int i = 0; i < 16; i++) shadow[i] = 4'h0;
    pend_g = 1'b0; pend_d = 1'b0; last_disp = 1'b1;

    // Reset: busy, no writes, no acks even with requests present
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", {31'd0, clear_busy}, 32'd1);
    chk("rst_we", {31'd0, bus.ram_we}, 32'd0);
    chk("rst_gack", {31'd0, bus.game_ack}, 32'd0);
    chk("rst_dack", {31'd0, bus.disp_ack}, 32'd0);
    chk("rst_grv", {31'd0, bus.game_rvalid}, 32'd0);
    chk("rst_drv", {31'd0, bus.disp_rvalid}, 32'd0);
    @(negedge clk);
    rst = 1'b0; bus.game_req = 1'b0; bus.disp_req = 1'b0;

    // Post-reset sweep: 16 writes of F to addresses 0..15
    sweep(16);

    // Contention for 6 cycles
    bus.game_req = 1'b1; bus.game_we = 1'b0; bus.game_addr = 4'd5;
    bus.disp_req = 1'b1; bus.disp_addr = 4'd9;
    run(6);

    // Game write then read-back of the same cell
    bus.disp_req = 1'b0;
    bus.game_we = 1'b1; bus.game_addr = 4'd5; bus.game_wdata = 4'd3;
    run(1);
    bus.game_we = 1'b0;
    run(1);

    // Clear request with a display read pending; owed game rvalid still issues
    bus.game_req = 1'b0;
    bus.disp_req = 1'b1; bus.disp_addr = 4'd9;
    clear_req = 1'b1;
    run(1);
    clear_req = 1'b0;
    sweep(16);
    run(1);
    bus.disp_req = 1'b0;
    bus.game_req = 1'b1; bus.game_addr = 4'd5;
    run(1);
    bus.game_req = 1'b0;
    run(1);

    // Reset in the middle of a clear restarts the sweep at address 0
    clear_req = 1'b1;
    run(1);
    clear_req = 1'b0;
    sweep(7);
    rst = 1'b1;
    #1;
    chk("midrst_we", {31'd0, bus.ram_we}, 32'd0);
    chk("midrst_busy", {31'd0, clear_busy}, 32'd1);
    @(negedge clk);
    rst = 1'b0; last_disp = 1'b1; pend_g = 1'b0; pend_d = 1'b0;
    sweep(16);

    // Contention right after reset: arbiter pointer is back to its reset value
    bus.game_req = 1'b1; bus.game_addr = 4'd5;
    bus.disp_req = 1'b1; bus.disp_addr = 4'd9;
    run(2);

    // Display read after clear
    bus.game_req = 1'b0;
    run(1);
    bus.disp_req = 1'b0;
    run(1);

    // Game writes a new value, display reads it back
    bus.game_req = 1'b1; bus.game_we = 1'b1; bus.game_addr = 4'd9; bus.game_wdata = 4'hA;
    run(1);
    bus.game_req = 1'b0; bus.game_we = 1'b0;
    bus.disp_req = 1'b1; bus.disp_addr = 4'd9;
    run(1);
    bus.disp_req = 1'b0;
    run(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
